// File: rtl/calc_display_scan.sv
// Four-digit seven-segment scanner with a double-buffered frame input and leading-zero blanking.
// Latency: an/seg_out are registered one cycle behind the scan state; a new frame is shown from the next frame boundary.
// Backpressure: load_ready drops while a frame is pending and rises the cycle after the next frame boundary.
module calc_display_scan #(
   parameter int REFRESH_DIV = 50000,
   parameter int BLANK_CYC   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load_valid,
   output logic       load_ready,
   input  logic [6:0] seg1,
   input  logic [6:0] seg2,
   input  logic [6:0] seg3,
   input  logic [6:0] seg4,
   input  logic       blank_lz,
   output logic [3:0] an,
   output logic [6:0] seg_out,
   output logic [1:0] digit_idx,
   output logic       frame_done
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0] LAST_CNT = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] BLANK_V  = CW'(BLANK_CYC);
   localparam logic [6:0]    ZERO_CODE = 7'b0111111;

   // code[0] is the most significant digit (seg1), code[3] the least (seg4)
   typedef struct packed {
      logic [3:0][6:0] code;
      logic            blank_lz;
   } frame_t;

   logic [CW-1:0] div_cnt;
   logic          tick;
   logic          boundary;
   logic          accept;
   logic          pend_full;
   frame_t        act_frame;
   frame_t        pend_frame;
   frame_t        in_frame;
   logic [3:0]    blanked;
   logic          lit;

   assign in_frame   = {seg4, seg3, seg2, seg1, blank_lz};
   assign tick       = (div_cnt == LAST_CNT);
   assign boundary   = tick && (digit_idx == 2'd3);
   assign load_ready = !pend_full;
   assign accept     = load_valid && load_ready;

   // A digit is blanked only if it and every more significant digit show zero; the last digit always shows
   always_comb begin
      blanked    = 4'b0000;
      blanked[0] = act_frame.blank_lz && (act_frame.code[0] == ZERO_CODE);
      blanked[1] = blanked[0] && (act_frame.code[1] == ZERO_CODE);
      blanked[2] = blanked[1] && (act_frame.code[2] == ZERO_CODE);
   end

   assign lit = (div_cnt >= BLANK_V) && !blanked[digit_idx];

   // Prescaler, scan index, frame pulse and the pending/active frame hand-over
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt    <= '0;
         digit_idx  <= 2'd0;
         frame_done <= 1'b0;
         pend_full  <= 1'b0;
         act_frame  <= '0;
         pend_frame <= '0;
      end else begin
         div_cnt    <= tick ? '0 : div_cnt + CW'(1);
         frame_done <= boundary;
         if (tick) begin
            digit_idx <= digit_idx + 2'd1;
         end
         if (boundary) begin
            // A full pending buffer blocks accept, so at most one of these branches has work to do
            if (pend_full) begin
               act_frame <= pend_frame;
               pend_full <= 1'b0;
            end else if (accept) begin
               act_frame <= in_frame;
            end
         end else if (accept) begin
            pend_frame <= in_frame;
            pend_full  <= 1'b1;
         end
      end
   end

   // Registered drive of the common-anode display: one enable low and inverted segments, or all off
   always_ff @(posedge clk) begin
      if (rst) begin
         an      <= 4'b1111;
         seg_out <= 7'b1111111;
      end else if (lit) begin
         an      <= ~(4'b0001 << digit_idx);
         seg_out <= ~act_frame.code[digit_idx];
      end else begin
         an      <= 4'b1111;
         seg_out <= 7'b1111111;
      end
   end

endmodule

// File: tb/tb_calc_display_scan.sv
// Bench for calc_display_scan: directed scenarios plus randomized loads against a cycle-count based model.
// Latency: outputs are compared 1 time unit after each rising edge against the model's registered view.
// Backpressure: the model derives load_ready from its own pending-frame bookkeeping.
module tb_calc_display_scan;

   localparam int R  = 8;
   localparam int B  = 2;
   localparam int FR = 4 * R;
   localparam logic [6:0] ZERO = 7'b0111111;

   logic       clk = 1'b0;
   logic       rst;
   logic       load_valid;
   logic       load_ready;
   logic [6:0] seg1, seg2, seg3, seg4;
   logic       blank_lz;
   logic [3:0] an;
   logic [6:0] seg_out;
   logic [1:0] digit_idx;
   logic       frame_done;

   int checks = 0;
   int errors = 0;

   // model state: t counts non-reset edges since the last reset
   int         t;
   logic [6:0] m_act [4];
   logic       m_act_bz;
   logic [6:0] m_pend [4];
   logic       m_pend_bz;
   logic       m_pend_full;
   logic [3:0] e_an;
   logic [6:0] e_seg;
   logic       e_fd;
   int         accepts;

   calc_display_scan #(.REFRESH_DIV(R), .BLANK_CYC(B)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .seg1       (seg1),
      .seg2       (seg2),
      .seg3       (seg3),
      .seg4       (seg4),
      .blank_lz   (blank_lz),
      .an         (an),
      .seg_out    (seg_out),
      .digit_idx  (digit_idx),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
      end
   endtask

   // Digit k is dark when blanking is on, k is not the last digit, and digits 0..k are all zero
   function automatic bit model_dark(input int k);
      if (k == 3 || !m_act_bz) return 1'b0;
      for (int j = 0; j <= k; j++)
         if (m_act[j] != ZERO) return 1'b0;
      return 1'b1;
   endfunction

   task automatic step(input logic r, input logic v, input logic [6:0] a, input logic [6:0] b,
                       input logic [6:0] c, input logic [6:0] d, input logic bz);
      int  slot, pos;
      bit  bnd, acc;
      rst = r; load_valid = v; seg1 = a; seg2 = b; seg3 = c; seg4 = d; blank_lz = bz;
      if (r) begin
         t = 0;
         for (int k = 0; k < 4; k++) m_act[k] = 7'd0;
         m_act_bz = 1'b0; m_pend_full = 1'b0;
         e_an = 4'b1111; e_seg = 7'b1111111; e_fd = 1'b0;
      end else begin
         pos  = t % R;
         slot = (t / R) % 4;
         bnd  = (t % FR) == FR - 1;
         acc  = v && !m_pend_full;
         if (acc) accepts++;
         if (pos < B || model_dark(slot)) begin
            e_an = 4'b1111; e_seg = 7'b1111111;
         end else begin
            for (int k = 0; k < 4; k++) e_an[k] = (k != slot);
            e_seg = ~m_act[slot];
         end
         e_fd = bnd;
         if (bnd && m_pend_full) begin
            m_act = m_pend; m_act_bz = m_pend_bz; m_pend_full = 1'b0;
         end else if (bnd && acc) begin
            m_act[0] = a; m_act[1] = b; m_act[2] = c; m_act[3] = d; m_act_bz = bz;
         end else if (acc) begin
            m_pend[0] = a; m_pend[1] = b; m_pend[2] = c; m_pend[3] = d; m_pend_bz = bz;
            m_pend_full = 1'b1;
         end
         t++;
      end
      @(posedge clk); #1;
      chk("an", {4'd0, an}, {4'd0, e_an});
      chk("seg_out", {1'b0, seg_out}, {1'b0, e_seg});
      chk("frame_done", {7'd0, frame_done}, {7'd0, e_fd});
      chk("load_ready", {7'd0, load_ready}, {7'd0, !m_pend_full});
      chk("digit_idx", {6'd0, digit_idx}, 8'((t / R) % 4));
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom), 1'($urandom));
   endtask

   task automatic run_to(input int p);
      for (int i = 0; i < 2 * FR && (t % FR) != p; i++) idle();
   endtask

   function automatic logic [6:0] rnd_code();
      return ($urandom_range(0, 1) == 1) ? ZERO : 7'($urandom);
   endfunction

   initial begin
      logic [6:0] hold_a;
      accepts = 0;
      t = 0;
      m_pend_full = 1'b0;
      // 1: reset values and first frame pulse 32 cycles after release
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0);
      chk("rst_an", {4'd0, an}, 8'h0f);
      chk("rst_seg", {1'b0, seg_out}, 8'h7f);
      chk("rst_ready", {7'd0, load_ready}, 8'd1);
      chk("rst_idx", {6'd0, digit_idx}, 8'd0);
      chk("rst_fd", {7'd0, frame_done}, 8'd0);
      for (int i = 0; i < 31; i++) idle();
      chk("fd_before_32", {7'd0, frame_done}, 8'd0);
      idle();
      chk("fd_at_32", {7'd0, frame_done}, 8'd1);

      // 2: "1234" mid-frame, no blanking
      run_to(10);
      step(1'b0, 1'b1, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110, 1'b0);
      chk("ready_drop", {7'd0, load_ready}, 8'd0);
      run_to(FR - 1);
      chk("ready_low_to_bnd", {7'd0, load_ready}, 8'd0);
      idle();
      chk("ready_after_bnd", {7'd0, load_ready}, 8'd1);
      for (int i = 0; i < R + B + 1; i++) idle();
      chk("slot1_an", {4'd0, an}, 8'h0d);
      chk("slot1_seg", {1'b0, seg_out}, {1'b0, ~7'b1011011});
      run_to(0);

      // 3: leading-zero blanking "0050" then "0000"
      run_to(5);
      step(1'b0, 1'b1, ZERO, ZERO, 7'b1101101, ZERO, 1'b1);
      run_to(0);
      for (int i = 0; i < 3 * R - 1; i++) idle();
      chk("lz_slot2_seg", {1'b0, seg_out}, {1'b0, ~7'b1101101});
      run_to(3);
      step(1'b0, 1'b1, ZERO, ZERO, ZERO, ZERO, 1'b1);
      run_to(0);
      for (int i = 0; i < FR; i++) idle();

      // 4: load exactly on the boundary bypasses pending
      run_to(FR - 1);
      step(1'b0, 1'b1, rnd_code(), rnd_code(), rnd_code(), rnd_code(), 1'($urandom));
      chk("bypass_ready", {7'd0, load_ready}, 8'd1);
      for (int i = 0; i < FR; i++) idle();

      // 5: valid held high with changing seg4: one accept per frame
      accepts = 0;
      hold_a = 7'($urandom);
      for (int i = 0; i < 3 * FR; i++)
         step(1'b0, 1'b1, hold_a, 7'b1001111, 7'b1011011, 7'($urandom), 1'b0);
      chk("hold_accepts", 8'(accepts), 8'd3);
      for (int i = 0; i < FR; i++) idle();

      // 6: reset at div_cnt 5 of slot 2 with a frame pending
      run_to(1);
      step(1'b0, 1'b1, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 1'b0);
      run_to(2 * R + 5);
      step(1'b1, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 1'b0);
      chk("mid_rst_ready", {7'd0, load_ready}, 8'd1);
      chk("mid_rst_an", {4'd0, an}, 8'h0f);
      for (int i = 0; i < 2 * FR; i++) idle();
      run_to(7);
      step(1'b0, 1'b1, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110, 1'b0);
      for (int i = 0; i < 2 * FR; i++) idle();

      // randomized loads, occasional zero digits to exercise blanking
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 9) == 0)
            step(1'b0, 1'b1, rnd_code(), rnd_code(), rnd_code(), rnd_code(), 1'($urandom));
         else
            idle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/calc_display_scan.md
# calc_display_scan

Time-multiplexed 4-digit seven-segment display scanner for the scientific calculator. It is the consumer end of the calculator's `seg1`..`seg4` digit outputs. It accepts a four-digit segment frame through a valid/ready handshake and double-buffers it, so updates land only on frame boundaries and the display never tears. It then drives a shared segment bus and one-hot digit enables for a common-anode board display.

## Interface
Parameters:
- `REFRESH_DIV`, default 50000: clock cycles per digit slot. Must be ≥ 2.
- `BLANK_CYC`, default 4: anti-ghost off-time at the start of each slot, in cycles. Must be < `REFRESH_DIV`.

Ports:
- `clk`  in  1  — system clock. This is the block's only clock.
- `rst`  in  1  — reset, synchronous, active-high.
- `load_valid`  in  1  — a new frame is offered on `seg1`..`seg4` and `blank_lz`.
- `load_ready`  out  1  — the block can accept a frame. A transfer occurs on a cycle with `load_valid && load_ready`.
- `seg1`  in  7  — most significant digit. Encoding is `{g,f,e,d,c,b,a}`, active-high, as produced by the calculator.
- `seg2`, `seg3`  in  7  — middle digits, same encoding.
- `seg4`  in  7  — least significant digit, same encoding.
- `blank_lz`  in  1  — enable leading-zero blanking for this frame.
- `an`  out  4  — digit enables, active-low. `an[0]` drives `seg1` … `an[3]` drives `seg4`.
- `seg_out`  out  7  — shared segment bus, active-low, bit order `{g,f,e,d,c,b,a}`.
- `digit_idx`  out  2  — index of the current scan slot, 0..3.
- `frame_done`  out  1  — one-cycle pulse at the end of slot 3.

## Operation
- **Prescaler.** `div_cnt` counts 0..`REFRESH_DIV`-1 and then wraps. `tick` = (`div_cnt` == `REFRESH_DIV`-1).
- **Scan.** On `tick`, `digit_idx` increments and wraps 3→0.
- **Frame boundary.** A boundary is `tick` with `digit_idx` == 3. `frame_done` is registered: it is high for the cycle after the boundary.
- **Buffers.**
  - The active buffer holds four codes plus a `blank_lz` bit.
  - The pending buffer holds the same fields plus a `pend_full` flag.
  - `load_ready` = !`pend_full`.
- **Accept, non-boundary cycle.** The frame is written to pending and `pend_full` is set.
- **Accept, boundary cycle.** This can only happen with `pend_full` = 0. The frame bypasses pending and is written directly to active.
- **Boundary with `pend_full` = 1.** Pending is copied to active and `pend_full` is cleared. `load_ready` returns high on the next cycle.
- **Holding.** Inputs are sampled only on accept. Changes while `load_valid` is low, or while `load_ready` is low, are ignored.
- **Leading-zero blanking.** Applies only when the active `blank_lz` = 1. The zero code is `7'b0111111`.
  - Digit k (k = 1..3) is blanked if its code equals the zero code and every more-significant digit is also blanked.
  - `seg4` is never blanked, so 0000 displays as "   0".
- **Anti-ghost.** When `div_cnt` < `BLANK_CYC`, all digits are off.
- **Output registers.** `an` and `seg_out` are registered and computed each cycle from the current `digit_idx`, `div_cnt` and active buffer.
  - **Lit state** (no anti-ghost, digit not blanked): `an` = ~(1 << `digit_idx`) and `seg_out` = ~code.
  - **Off state** (anti-ghost, or blanked digit): `an` = 4'b1111 and `seg_out` = 7'b1111111.
- **Reset.** Synchronous reset applies the following on the next edge, regardless of any operation in progress:
  - `div_cnt` = 0, `digit_idx` = 0.
  - Active codes = 7'b0000000 (blank) and active `blank_lz` = 0.
  - `pend_full` = 0, so `load_ready` = 1.
  - `an` = 4'b1111, `seg_out` = 7'b1111111, `frame_done` = 0.
  - Any pending frame is discarded.

## Timing
- **Digit slot.** Each slot is exactly `REFRESH_DIV` cycles. A frame is 4 × `REFRESH_DIV` cycles.
- **Output latency.** `an`/`seg_out` lag the internal state by 1 cycle.
  - With `BLANK_CYC` > 0, a slot's enable goes low in the cycle after `div_cnt` reaches `BLANK_CYC`.
  - It goes high again (4'b1111) in the cycle after the next slot begins.
- **Load to display.**
  - Best case (accept on a boundary): the new data lights slot 0 of the next frame.
  - Worst case: just under 1 frame plus `BLANK_CYC` + 1 cycles.
- **`load_ready` low interval.** From the cycle after accept through the boundary cycle. It is high again in the cycle after the boundary.
- **Back-to-back loads.** At most one frame per display frame. `load_valid` held high is accepted again the cycle after `load_ready` rises.
- **Reset, first slot.** After `rst` deasserts, the first slot is digit 0 with `div_cnt` = 0. The first boundary occurs 4 × `REFRESH_DIV` − 1 cycles after the first non-reset edge.

## Test plan
Use `REFRESH_DIV` = 8 and `BLANK_CYC` = 2 for all scenarios.
1. **Reset values.** Assert `rst` for 3 cycles → `an` = 4'b1111, `seg_out` = 7'b1111111, `load_ready` = 1, `digit_idx` = 0, `frame_done` = 0. After release, `frame_done` first pulses 32 cycles later.
2. **Full frame, no blanking.** Load "1234" (codes 0000110, 1011011, 1001111, 1100110) with `blank_lz` = 0 mid-frame.
   - `load_ready` drops the next cycle and rises the cycle after the boundary.
   - In the next frame, each slot shows 2 off cycles, then 6 cycles with the correct `an` one-hot-low and inverted code.
3. **Leading-zero blanking.** Load "0050" with `blank_lz` = 1 → slots 0 and 1 stay dark, slot 2 shows ~1101101, slot 3 shows ~0111111. Load "0000" → only slot 3 lit.
4. **Boundary bypass.** Assert `load_valid` exactly on the slot-3 `tick` with `pend_full` = 0 → the data appears in slot 0 of the immediately following frame and `load_ready` stays 1.
5. **Double load and hold.** Hold `load_valid` = 1 with a changing `seg4` → exactly one accept per frame. Values offered while `load_ready` = 0 are never displayed.
6. **Reset mid-operation.** Accept a frame, then assert `rst` at `div_cnt` = 5 of slot 2 before the boundary → the pending frame is dropped, the display is dark and `load_ready` = 1. A frame loaded afterward displays normally.
